// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion loop: common width, reset code and
// the sequencer state encoding.
package sar_pkg;

  localparam int unsigned SAR_WIDTH = 16;

  // Code the SAR register restarts at: MSB set, all other bits clear.
  localparam logic [SAR_WIDTH-1:0] SAR_RESET_CODE = {1'b1, {(SAR_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConvert,
    StDone
  } sar_state_e;

endpackage

// File: rtl/sar_comparator_frontend.sv
// Comparator end of the SAR loop: samples an input word, restarts the SAR
// register, answers each trial code and publishes the converged result.
module sar_comparator_frontend
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] vin,
  input  logic [WIDTH-1:0] trial_code,
  output logic             comparator_out,
  output logic             sar_rst,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      sample_q       <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_q       <= sample_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sample_d = vin;
          state_d  = StSample;
        end
      end
      StSample: begin
        cnt_d   = '0;
        state_d = StConvert;
      end
      StConvert: begin
        // Exit on the last compare edge so the counter never wraps.
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        result_d       = trial_code;
        result_valid_d = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign sar_rst        = rst | (state_q == StSample);
  assign busy           = (state_q != StIdle);
  assign comparator_out = (state_q == StConvert) && (sample_q >= trial_code);
  assign result         = result_q;
  assign result_valid   = result_valid_q;

endmodule

// File: doc/sar_comparator_frontend.md
Name: sar_comparator_frontend

Overview:
- Companion to the 16-bit SAR register, driving the comparator end of its interface.
- On a start request it samples an input word, then resets the SAR register.
- It then answers the register's trial code with a comparator decision on each of WIDTH cycles.
- Finally it captures the converged code as the conversion result with a valid pulse.
- Serves as the digital analog-front-end model and conversion sequencer in the SAR loop.

Parameters:
- WIDTH, 16, conversion width in bits; must match the SAR register width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled on a clk edge, accepted only in IDLE.
- vin  input  WIDTH  unsigned input word; sampled on the accepting edge.
- trial_code  input  WIDTH  current SAR register output.
- comparator_out  output  1  decision to the SAR register.
- sar_rst  output  1  reset to the SAR register.
- busy  output  1  conversion in progress.
- result  output  WIDTH  last completed conversion.
- result_valid  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset (async) values:
  - state = IDLE; sample = 0; bit counter = 0.
  - result = 0; result_valid = 0.
  - busy = 0; comparator_out = 0.
  - sar_rst = 1 while rst is high.
- States: IDLE, SAMPLE, CONVERT, DONE. Edge E0 is the edge that accepts start.
- IDLE:
  - start high at an edge → sample <= vin, go to SAMPLE.
  - start low → stay in IDLE.
- SAMPLE (one cycle, after E0):
  - sar_rst = 1, so the SAR register restarts at its reset code (MSB set).
  - At E1 → CONVERT, counter <= 0.
- CONVERT (WIDTH cycles; compare edges E2 .. E(WIDTH+1)):
  - comparator_out = (sample >= trial_code), unsigned and combinational from registered sample and live trial_code.
  - The counter increments each edge.
  - At the edge where counter == WIDTH-1 → DONE.
- DONE (one cycle, trial_code is final):
  - At E(WIDTH+2): result <= trial_code, result_valid <= 1 for exactly one cycle, state → IDLE.
- Output decodes:
  - sar_rst = rst OR (state == SAMPLE).
  - busy = (state != IDLE), registered-state decode.
  - comparator_out = 0 outside CONVERT.
- Timing and result rules:
  - result_valid rises at E0+WIDTH+2 (E18 for WIDTH=16), the same edge busy falls.
  - result holds until the next completed conversion.
  - With a correct SAR register, result == sample.
- start handling:
  - start while busy (SAMPLE, CONVERT, DONE) is ignored, with no queuing.
  - sample is frozen for the whole conversion; vin changes after E0 have no effect.
  - start held continuously → back-to-back conversions. The first start after returning to IDLE is accepted one edge after result_valid rises, so each conversion takes WIDTH+3 edges.
- Reset mid-conversion:
  - Immediate return to IDLE; sar_rst asserted.
  - result and result_valid cleared; a partial code is never published.
- Counter width: clog2(WIDTH); no wrap occurs because CONVERT exits at WIDTH-1.

Decomposition:
- Shared package sar_pkg holds:
  - the state enum (IDLE, SAMPLE, CONVERT, DONE);
  - SAR_WIDTH = 16, used by both the SAR register and this block;
  - the SAR reset code constant (1 << (WIDTH-1)).
- No sub-module required; a single FSM plus counter and sample register.
- Bench top instantiates this block with the SAR register, with trial_code/comparator_out/sar_rst connected in a loop.

Test Plan:
- vin = 0x1234, single start pulse:
  - busy high E0..E18; result_valid pulse at E18.
  - result = 0x1234; comparator_out sequence MSB-first = 0,0,0,1,0,0,1,0,0,0,1,1,0,1,0,0.
- Corner values in separate conversions:
  - vin = 0x0000 → result 0x0000, comparator_out all 0.
  - vin = 0xFFFF → result 0xFFFF, comparator_out all 1.
  - vin = 0x8000 → result 0x8000.
- start re-pulsed during CONVERT with vin changed to 0xAAAA (original vin 0x5555) → ignored; result = 0x5555, single result_valid pulse.
- start held high for 3 conversions with vin = 0x0001, 0x7FFF, 0xC3A5 sampled at each accepting edge:
  - results 0x0001, 0x7FFF, 0xC3A5;
  - result_valid pulses 19 edges apart.
- rst asserted at E9 of a vin = 0xBEEF conversion:
  - busy and result_valid drop, and result reads 0, asynchronously;
  - sar_rst high during rst;
  - subsequent start with vin = 0x0F0F → result 0x0F0F.
- Check result_valid is never high in two consecutive cycles, and comparator_out is 0 in IDLE, SAMPLE and DONE across all scenarios.
